// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared mode type and select helper for mux_scan_reg
package mux_scan_pkg;

   // Operating mode of the multiplexer
   typedef enum logic {
      MODE_DIRECT = 1'b0,
      MODE_SCAN   = 1'b1
   } mode_e;

   // Clamp a select value into the legal channel range 0..n-1
   function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned n);
      return (sel >= n) ? (n - 1) : sel;
   endfunction

endpackage

// File: rtl/mux_scan_next.sv
// rtl/mux_scan_next.sv - circular next-enabled-channel finder (built only with MUX_SCAN_MASK_EN)
`ifdef MUX_SCAN_MASK_EN
module mux_scan_next #(
   parameter int N  = 4,
   parameter int SW = $clog2(N)
) (
   input  logic [SW-1:0] i_ptr,
   input  logic [N-1:0]  i_mask,
   output logic [SW-1:0] o_next,
   output logic          o_last
);

   logic [SW-1:0] w_first;
   logic [SW-1:0] w_first_above;
   logic          w_above;

   // Lowest enabled channel overall and lowest enabled channel above i_ptr
   always_comb begin
      w_first       = i_ptr;
      w_first_above = i_ptr;
      w_above       = 1'b0;
      for (int j = N - 1; j >= 0; j--) begin
         if (i_mask[j]) begin
            w_first = SW'(j);
            if (SW'(j) > i_ptr) begin
               w_first_above = SW'(j);
               w_above       = 1'b1;
            end
         end
      end
   end

   // Wrap to the lowest enabled channel when nothing is enabled above i_ptr;
   // with an all-zero mask the pointer is returned unchanged
   assign o_next = w_above ? w_first_above : w_first;
   assign o_last = i_mask[i_ptr] & ~w_above;

endmodule
`endif

// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - N-channel registered mux with valid/ready output and scan mode; option MUX_SCAN_MASK_EN
module mux_scan_reg
   import mux_scan_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 1,
   parameter int SW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            mode,
   input  logic [SW-1:0]   sel,
`ifdef MUX_SCAN_MASK_EN
   input  logic [N-1:0]    ch_mask,
`endif
   output logic [W-1:0]    out_data,
   output logic [SW-1:0]   out_ch,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_wrap
);

   logic [W-1:0]  r_out_data;
   logic [SW-1:0] r_out_ch;
   logic          r_out_valid;
   logic          r_out_wrap;
   logic [SW-1:0] r_ptr;

   logic [N-1:0]  w_mask;
   logic          w_mask_any;
   logic          w_mode_scan;
   logic          w_in_ready;
   logic          w_acc;
   logic [SW-1:0] w_scan_ch;
   logic [SW-1:0] w_ch;
   logic [SW-1:0] w_ch_next;
   logic          w_ch_last;
   logic [SW-1:0] w_sel_clamped;
   logic [W-1:0]  w_data;

`ifdef MUX_SCAN_MASK_EN
   logic [SW-1:0] w_skip_next;
   logic          w_unused_skip_last;

   assign w_mask = ch_mask;

   // Where the pointer rests on a disabled channel, scan from the next enabled one
   mux_scan_next #(.N(N), .SW(SW)) u_skip (
      .i_ptr  (r_ptr),
      .i_mask (w_mask),
      .o_next (w_skip_next),
      .o_last (w_unused_skip_last)
   );

   // Successor of the accepted channel and whether it closes a scan round
   mux_scan_next #(.N(N), .SW(SW)) u_adv (
      .i_ptr  (w_ch),
      .i_mask (w_mask),
      .o_next (w_ch_next),
      .o_last (w_ch_last)
   );

   assign w_scan_ch = w_mask[r_ptr] ? r_ptr : w_skip_next;
`else
   assign w_mask    = {N{1'b1}};
   assign w_scan_ch = r_ptr;
   assign w_ch_last = (w_ch == SW'(N - 1));
   assign w_ch_next = w_ch_last ? '0 : (w_ch + 1'b1);
`endif

   assign w_mask_any    = |w_mask;
   assign w_mode_scan   = (mode_e'(mode) == MODE_SCAN);
   assign w_sel_clamped = SW'(clamp_sel(32'(sel), N));
   assign w_ch          = w_mode_scan ? w_scan_ch : sel;

   // Ready whenever the output slot is empty or being drained this cycle
   assign w_in_ready = (~r_out_valid | out_ready) & w_mask_any;
   assign w_acc      = in_valid & w_in_ready;

   // Pick the chosen channel; out-of-range or disabled channels read as zero
   always_comb begin
      w_data = '0;
      for (int k = 0; k < N; k++) begin
         if ((w_ch == SW'(k)) && w_mask[k]) begin
            w_data = in_data[k*W +: W];
         end
      end
   end

   // Output stage: capture on accept, clear valid on drain, otherwise hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_data  <= '0;
         r_out_ch    <= '0;
         r_out_valid <= 1'b0;
         r_out_wrap  <= 1'b0;
      end else if (w_acc) begin
         r_out_data  <= w_data;
         r_out_ch    <= w_ch;
         r_out_valid <= 1'b1;
         r_out_wrap  <= w_mode_scan & w_ch_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   // Scan pointer: follows the clamped select in direct mode, steps on accept in scan mode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (!w_mask_any) begin
         r_ptr <= r_ptr;
      end else if (!w_mode_scan) begin
         r_ptr <= w_sel_clamped;
      end else if (w_acc) begin
         r_ptr <= w_ch_next;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_data  = r_out_data;
   assign out_ch    = r_out_ch;
   assign out_valid = r_out_valid;
   assign out_wrap  = r_out_wrap;

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb/tb_mux_scan_reg.sv - self-checking bench for mux_scan_reg (N=4 and N=3 instances)
module tb_mux_scan_reg;

   localparam int N  = 4;
   localparam int W  = 8;
   localparam int SW = 2;
   localparam int N3 = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic [N*W-1:0] in_data;
   logic           in_valid, in_ready, mode, out_ready, out_valid, out_wrap;
   logic [SW-1:0]  sel, out_ch;
   logic [W-1:0]   out_data;
   logic [N-1:0]   ch_mask;

   logic [N3*W-1:0] in_data3;
   logic            in_valid3, in_ready3, mode3, out_ready3, out_valid3, out_wrap3;
   logic [1:0]      sel3, out_ch3;
   logic [W-1:0]    out_data3;
`ifdef MUX_SCAN_MASK_EN
   logic [N3-1:0]   ch_mask3;
`endif

   mux_scan_reg #(.N(N), .W(W)) u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .sel(sel),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask(ch_mask),
`endif
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready), .out_wrap(out_wrap)
   );

   mux_scan_reg #(.N(N3), .W(W)) u_dut3 (
      .clk(clk), .rst(rst), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
      .mode(mode3), .sel(sel3),
`ifdef MUX_SCAN_MASK_EN
      .ch_mask(ch_mask3),
`endif
      .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
      .out_ready(out_ready3), .out_wrap(out_wrap3)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: the output register contents and the scan position
   logic       m_valid, m_wrap;
   logic [7:0] m_data;
   int         m_ch, m_ptr;

   function automatic int next_en(input int p, input logic [N-1:0] m);
      for (int k = 1; k <= N; k++) if (m[(p + k) % N]) return (p + k) % N;
      return p;
   endfunction

   function automatic int top_en(input logic [N-1:0] m);
      for (int k = N - 1; k >= 0; k--) if (m[k]) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_wrap = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
   endtask

   task automatic model_step();
      bit rdy, acc;
      int ch;
      rdy = (!m_valid || out_ready) && (ch_mask != '0);
      acc = in_valid && rdy;
      if (mode) ch = ch_mask[m_ptr] ? m_ptr : next_en(m_ptr, ch_mask);
      else      ch = int'(sel);
      if (acc) begin
         m_data  = (ch < N && ch_mask[ch]) ? in_data[ch*W +: W] : 8'h00;
         m_ch    = ch;
         m_valid = 1'b1;
         m_wrap  = mode && (ch == top_en(ch_mask));
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
      end
      if (ch_mask != '0) begin
         if (!mode)    m_ptr = (int'(sel) >= N) ? N - 1 : int'(sel);
         else if (acc) m_ptr = next_en(ch, ch_mask);
      end
   endtask

   // One clock with inputs already driven: check in_ready, advance, check outputs
   task automatic tick(input string tag);
      #1;
      chk({tag, " in_ready"}, 32'(in_ready),
          32'((!m_valid || out_ready) && (ch_mask != '0)));
      model_step();
      @(posedge clk); #1;
      chk({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
      chk({tag, " out_data"},  32'(out_data),  32'(m_data));
      chk({tag, " out_ch"},    32'(out_ch),    32'(m_ch));
      chk({tag, " out_wrap"},  32'(out_wrap),  32'(m_wrap));
   endtask

   typedef struct {
      logic       mode;
      logic [1:0] sel;
      logic       iv;
      logic       ordy;
      logic       irdy;
      logic [7:0] d;
      logic [1:0] ch;
      logic       v;
      logic       w;
   } vec_t;

   vec_t vecs [21];

   initial begin
      vecs = '{
         '{1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0},
         '{1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0},
         '{1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0},
         '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 8'h44, 2'd3, 1'b0, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b1},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h33, 2'd2, 1'b1, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b1},
         '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h44, 2'd3, 1'b1, 1'b1},
         '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h44, 2'd3, 1'b1, 1'b1},
         '{1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 8'h44, 2'd3, 1'b1, 1'b1},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1, 1'b0},
         '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 8'h22, 2'd1, 1'b1, 1'b0},
         '{1'b0, 2'd3, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0},
         '{1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 8'h44, 2'd3, 1'b1, 1'b1},
         '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 8'h44, 2'd3, 1'b1, 1'b1},
         '{1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 8'h44, 2'd3, 1'b0, 1'b1}
      };

      in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      in_valid = 1'b0; mode = 1'b0; sel = 2'd0; out_ready = 1'b1; ch_mask = '1;
      in_data3 = {8'hC3, 8'hB2, 8'hA1};
      in_valid3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;
`ifdef MUX_SCAN_MASK_EN
      ch_mask3 = '1;
`endif
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_data",  32'(out_data),  32'd0);
      chk("reset out_ch",    32'(out_ch),    32'd0);
      chk("reset out_wrap",  32'(out_wrap),  32'd0);
      rst = 1'b0;

      // N=3 instance: out-of-range select, clamped pointer entering scan
      in_valid3 = 1'b1; sel3 = 2'd3;
      @(posedge clk); #1;
      chk("n3 oor data",  32'(out_data3),  32'd0);
      chk("n3 oor ch",    32'(out_ch3),    32'd3);
      chk("n3 oor valid", 32'(out_valid3), 32'd1);
      chk("n3 in_ready",  32'(in_ready3),  32'd1);
      sel3 = 2'd2;
      @(posedge clk); #1;
      chk("n3 sel2 data", 32'(out_data3), 32'hC3);
      chk("n3 sel2 ch",   32'(out_ch3),   32'd2);
      sel3 = 2'd3;
      @(posedge clk); #1;
      mode3 = 1'b1;
      @(posedge clk); #1;
      chk("n3 scan0 ch",   32'(out_ch3),   32'd2);
      chk("n3 scan0 data", 32'(out_data3), 32'hC3);
      chk("n3 scan0 wrap", 32'(out_wrap3), 32'd1);
      @(posedge clk); #1;
      chk("n3 scan1 ch",   32'(out_ch3),   32'd0);
      chk("n3 scan1 wrap", 32'(out_wrap3), 32'd0);
      @(posedge clk); #1;
      chk("n3 scan2 data", 32'(out_data3), 32'hB2);
      in_valid3 = 1'b0;

      // Directed vectors on the N=4 instance
      for (int i = 0; i < $size(vecs); i++) begin
         mode = vecs[i].mode; sel = vecs[i].sel;
         in_valid = vecs[i].iv; out_ready = vecs[i].ordy;
         #1;
         chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].irdy));
         @(posedge clk); #1;
         chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].v));
         chk($sformatf("vec%0d out_data", i),  32'(out_data),  32'(vecs[i].d));
         chk($sformatf("vec%0d out_ch", i),    32'(out_ch),    32'(vecs[i].ch));
         chk($sformatf("vec%0d out_wrap", i),  32'(out_wrap),  32'(vecs[i].w));
      end

      // Asynchronous reset while a sample is stalled
      mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("prerst valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0; out_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async rst valid", 32'(out_valid), 32'd0);
      chk("async rst data",  32'(out_data),  32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      in_valid = 1'b1; out_ready = 1'b1; sel = 2'd2;
      tick("post rst");
      chk("post rst scan ch0", 32'(out_ch), 32'd0);

`ifdef MUX_SCAN_MASK_EN
      // Masked scan skips disabled channels; empty mask blocks accepts
      ch_mask = 4'b1010; mode = 1'b0; sel = 2'd0; in_valid = 1'b0;
      tick("mask prep");
      mode = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick($sformatf("mask scan%0d", i));
         chk($sformatf("mask ch%0d", i),   32'(out_ch),   (i % 2 == 0) ? 32'd1 : 32'd3);
         chk($sformatf("mask wrap%0d", i), 32'(out_wrap), (i % 2 == 0) ? 32'd0 : 32'd1);
      end
      ch_mask = 4'b0000;
      tick("mask zero");
      chk("mask zero valid", 32'(out_valid), 32'd0);
      ch_mask = '1;
`endif

      // Randomised traffic against the model
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 7) == 0) mode = ~mode;
         sel       = 2'($urandom_range(0, 3));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         in_data   = {$urandom};
`ifdef MUX_SCAN_MASK_EN
         if ($urandom_range(0, 9) == 0) ch_mask = 4'($urandom_range(0, 15));
`endif
         tick($sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
